pipelined_prefix_adder: RTL and testbench



---
 rtl/pipelined_prefix_adder.sv | 168 ++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
//
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
// Each operand bit is reduced to a 2-bit carry class (00 kill, 01 propagate,
// 11 generate). The effective carry-in is injected below bit 0 as an extra
// class entry. The prefix tree is split into stages of LEVELS_PER_STAGE
// levels, and every stage is separated by registers. The whole pipeline
// shifts together whenever the output slot is empty or being drained.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake (in_ready = pipeline advances)
//   a, b                operands (WIDTH bits)
//   cin                 carry-in, used in add mode only
//   op_sub              0: a + b + cin, 1: a - b
//   tag_in              opaque tag carried alongside the operands
//   out_valid, out_ready output handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
//   tag_out             tag of the presented result

module pipelined_prefix_adder #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    // The injected carry-in occupies entry 0, so the tree spans WIDTH+1 entries.
    localparam int NLEVELS = $clog2(WIDTH + 1);
    localparam int NSTAGES = (NLEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Entry j holds the class of bit j-1. After the full tree, entry j is the
    // carry into bit j.
    typedef logic [WIDTH:0][1:0] cls_t;

    cls_t             cls_q [0:NSTAGES];
    logic [WIDTH-1:0] p_q   [0:NSTAGES];
    logic [TAG_W-1:0] tag_q [0:NSTAGES];
    logic             vld_q [0:NSTAGES];

    cls_t             cls_d [1:NSTAGES];
    cls_t             cls0;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             advance;

    // The higher class wins unless it only propagates, in which case the
    // lower class decides.
    function automatic logic [1:0] combine(input logic [1:0] hi, input logic [1:0] lo);
        return (hi != 2'b01) ? hi : lo;
    endfunction

    // Apply up to LEVELS_PER_STAGE tree levels, starting at level 'first'.
    // Levels beyond the tree depth pass through unchanged. Entries below the
    // span of a level are already complete prefixes, so they also pass through.
    function automatic cls_t apply_levels(input cls_t c, input int first);
        cls_t cur;
        cls_t nxt;
        int   k;
        int   span;
        cur = c;
        for (int l = 0; l < LEVELS_PER_STAGE; l++) begin
            k = first + l;
            if (k < NLEVELS) begin
                span = 1 << k;
                nxt  = cur;
                for (int j = 0; j <= WIDTH; j++) begin
                    if (j >= span) begin
                        nxt[j] = combine(cur[j], cur[j - span]);
                    end
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    // The output slot drives the whole pipeline. Every stage moves when the
    // slot is empty or being consumed, so in_ready never depends on in_valid.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction becomes a + ~b + 1. Each bit's class is {a&b, a|b}, which
    // yields 00/01/11 directly. The carry-in class is either kill or generate.
    always_comb begin
        b_eff   = op_sub ? ~b : b;
        c_eff   = op_sub | cin;
        cls0    = '0;
        cls0[0] = {c_eff, c_eff};
        for (int i = 0; i < WIDTH; i++) begin
            cls0[i+1] = {a[i] & b_eff[i], a[i] | b_eff[i]};
        end
    end

    // Prefix levels between consecutive pipeline registers.
    for (genvar s = 1; s <= NSTAGES; s++) begin : g_stage
        assign cls_d[s] = apply_levels(cls_q[s-1], (s - 1) * LEVELS_PER_STAGE);
    end

    // The fully resolved classes are only 00 or 11, so the upper bit of each
    // entry is the carry into that bit position.
    always_comb begin
        carry = '0;
        for (int j = 0; j <= WIDTH; j++) begin
            carry[j] = cls_q[NSTAGES][j][1];
        end
        sum_d  = p_q[NSTAGES] ^ carry[WIDTH-1:0];
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
    end

    // Pipeline registers.
    // The result fields only load on a valid result, so they keep their
    // reset values until the first result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= NSTAGES; s++) begin
                cls_q[s] <= '0;
                p_q[s]   <= '0;
                tag_q[s] <= '0;
                vld_q[s] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            tag_out   <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            cls_q[0] <= cls0;
            p_q[0]   <= a ^ b_eff;
            tag_q[0] <= tag_in;
            for (int s = 1; s <= NSTAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                cls_q[s] <= cls_d[s];
                p_q[s]   <= p_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
            out_valid <= vld_q[NSTAGES];
            if (vld_q[NSTAGES]) begin
                sum     <= sum_d;
                cout    <= cout_d;
                ovf     <= ovf_d;
                tag_out <= tag_q[NSTAGES];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb_pipelined_prefix_adder
//
// Drives a 32-bit instance (one level per stage, latency 7) and an 8-bit
// instance (two levels per stage, latency 3). Results are compared against
// an arithmetic reference model through an in-order scoreboard.

module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid, in_ready, cin, op_sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    logic [3:0]  tag_in, tag_out;

    // 8-bit instance
    logic        in_valid8, in_ready8, cin8, op_sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic [3:0]  tag_in8, tag_out8;

    pipelined_prefix_adder #(.WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .tag_out(tag_out)
    );

    pipelined_prefix_adder #(.WIDTH(8), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .op_sub(op_sub8), .tag_in(tag_in8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .tag_out(tag_out8)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_out_cyc = 0;
    logic sel = 1'b0;
    logic fin, fout;

    // View of whichever instance is currently selected.
    logic        v_in_ready, v_out_valid, v_cout, v_ovf;
    logic [31:0] v_sum;
    logic [3:0]  v_tag;

    always_comb begin
        if (sel) begin
            v_in_ready  = in_ready8;
            v_out_valid = out_valid8;
            v_sum       = {24'b0, sum8};
            v_cout      = cout8;
            v_ovf       = ovf8;
            v_tag       = tag_out8;
        end else begin
            v_in_ready  = in_ready;
            v_out_valid = out_valid;
            v_sum       = sum;
            v_cout      = cout;
            v_ovf       = ovf;
            v_tag       = tag_out;
        end
    end

    always @(posedge clk) cyc++;

    // Reference: plain integer arithmetic on w-bit operands, with overflow
    // taken from the operand and result signs.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub,
                                   input logic [3:0] mtag, input int w);
        exp_t        r;
        logic [32:0] full;
        logic [31:0] mask, aa, be;
        logic        ce;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        aa     = ma & mask;
        be     = (msub ? ~mb : mb) & mask;
        ce     = msub ? 1'b1 : mcin;
        full   = {1'b0, aa} + {1'b0, be} + {32'b0, ce};
        r.sum  = full[31:0] & mask;
        r.cout = full[w];
        r.ovf  = (aa[w-1] == be[w-1]) && (r.sum[w-1] != aa[w-1]);
        r.tag  = mtag;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, sample handshakes 1 unit later,
    // score any result leaving, record any operand entering, then cross the
    // rising edge and return at the next negedge.
    task automatic step(input logic iv, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tcin, input logic tsub, input logic [3:0] tt,
                        input logic ordy);
        exp_t e;
        if (!sel) begin
            in_valid = iv; a = ta; b = tb_; cin = tcin; op_sub = tsub;
            tag_in = tt; out_ready = ordy; in_valid8 = 1'b0; out_ready8 = 1'b1;
        end else begin
            in_valid8 = iv; a8 = ta[7:0]; b8 = tb_[7:0]; cin8 = tcin; op_sub8 = tsub;
            tag_in8 = tt; out_ready8 = ordy; in_valid = 1'b0; out_ready = 1'b1;
        end
        #1;
        fin  = iv && v_in_ready;
        fout = v_out_valid && ordy;
        if (fout) begin
            if (sbq.size() == 0) begin
                check("queue_nonempty", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                check("sum", v_sum, e.sum);
                check("cout", v_cout, e.cout);
                check("ovf", v_ovf, e.ovf);
                check("tag", v_tag, e.tag);
                last_out_cyc = cyc;
            end
        end
        if (fin) sbq.push_back(model(ta, tb_, tcin, tsub, tt, sel ? 8 : 32));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, ordy);
    endtask

    // Issue one op into an empty pipeline, measure the edges until out_valid,
    // and check the presented result against fixed values before it drains.
    task automatic run_directed(input logic [31:0] ta, input logic [31:0] tb_,
                                input logic tcin, input logic tsub,
                                input logic [31:0] esum, input logic ecout,
                                input logic eovf, input int lat_exp);
        int lat;
        step(1'b1, ta, tb_, tcin, tsub, 4'hA, 1'b1);
        lat = 0;
        while (!v_out_valid && lat < 50) begin
            idle(1'b1);
            lat++;
        end
        check("latency", lat, lat_exp);
        check("dir_sum", v_sum, esum);
        check("dir_cout", v_cout, ecout);
        check("dir_ovf", v_ovf, eovf);
        idle(1'b1);
    endtask

    // Offer one op until it is accepted, with a random output-ready pattern.
    task automatic offer(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tcin, input logic tsub, input logic [3:0] tt);
        int tries;
        tries = 0;
        fin = 1'b0;
        while (!fin && tries < 100) begin
            step(1'b1, ta, tb_, tcin, tsub, tt, $urandom_range(0, 9) < 7);
            tries++;
        end
        if (!fin) check("accept_timeout", tries, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   t, cnt, first_c;
        exp_t e;
        logic [31:0] ra, rb;
        logic [7:0]  cv [5];

        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; cin = 0; op_sub = 0; tag_in = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; op_sub8 = 0; tag_in8 = 0; out_ready8 = 1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tag", tag_out, 0);
        check("rst_out_valid8", out_valid8, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // 32-bit directed corner cases
        sel = 1'b0;
        run_directed(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 7);
        run_directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 7);
        run_directed(32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 7);
        run_directed(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 7);
        run_directed(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b1, 32'h0246_8ACF, 1'b1, 1'b0, 7);

        // Backpressure: only the in-flight capacity is accepted, and the
        // output stays frozen on the oldest result.
        t = 0;
        for (int i = 0; i < 20; i++) begin
            step(t < 12, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'(t), 1'b0);
            if (fin) t++;
        end
        check("bp_accepted", t, 8);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_frozen_tag", tag_out, sbq[0].tag);
        check("bp_frozen_sum", sum, sbq[0].sum);
        cnt = 0;
        first_c = 0;
        for (int i = 0; i < 40 && cnt < 12; i++) begin
            step(t < 12, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'(t), 1'b1);
            if (fin) t++;
            if (fout) begin
                if (cnt == 0) first_c = last_out_cyc;
                cnt++;
            end
        end
        check("bp_out_count", cnt, 12);
        check("bp_no_gaps", last_out_cyc - first_c, 11);
        drain();

        // Asynchronous reset with transactions in flight
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 4'(i), 1'b0);
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_drop_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_in_ready", in_ready, 1);
        sbq.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            check("no_stale_out", out_valid, 0);
            idle(1'b1);
        end
        ra = $urandom;
        rb = $urandom;
        e  = model(ra, rb, 1'b0, 1'b0, 4'hA, 32);
        run_directed(ra, rb, 1'b0, 1'b0, e.sum, e.cout, e.ovf, 7);

        // 32-bit random traffic with random backpressure
        t = 0;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 9) < 8, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'(t), $urandom_range(0, 9) < 7);
            if (fin) t++;
        end
        drain();

        // 8-bit instance with two levels per stage
        sel = 1'b1;
        run_directed(32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 3);
        run_directed(32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, 3);
        cv[0] = 8'h00; cv[1] = 8'h01; cv[2] = 8'h7F; cv[3] = 8'h80; cv[4] = 8'hFF;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int c = 0; c < 4; c++) begin
                    offer({24'b0, cv[i]}, {24'b0, cv[j]}, c[0], c[1], 4'(t));
                    t++;
                end
            end
        end
        for (int i = 0; i < 800; i++) begin
            offer($urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'(t));
            t++;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
